// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// latency counter width and a byte-merge helper for strobed stores.
package data_mem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM-stage initiator and the data-memory responder.
// REQ_BE exists only when BYTE_STROBE_EN is defined.
interface data_mem_responder_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
`ifdef BYTE_STROBE_EN
    logic [3:0]  REQ_BE;
`endif
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        BUSY;

`ifdef BYTE_STROBE_EN
    modport master (output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BE, RSP_READY,
                    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY);
    modport slave  (input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BE, RSP_READY,
                    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY);
`else
    modport master (output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
                    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY);
    modport slave  (input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
                    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY);
`endif

endinterface

// File: rtl/data_mem_array.sv
// Single-port synchronous word array built from four byte lanes, each with its own
// write strobe and a registered read that can be cleared to zero.
module data_mem_array #(
    parameter int DEPTH_WORDS = 512,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          rd_en,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (we && be[gi]) lane_mem[addr] <= wdata[8*gi +: 8];
            end

            // The read register doubles as the response data register, hence the clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_q <= 8'h00;
                end else if (rd_en) begin
                    lane_q <= lane_mem[addr];
                end else if (clr) begin
                    lane_q <= 8'h00;
                end
            end

            assign rdata[8*gi +: 8] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store in flight, LATENCY wait cycles, response held
// until taken. Define BYTE_STROBE_EN to enable REQ_BE byte-strobed stores.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 2
) (
    input logic                 CLK,
    input logic                 RESET_N,
    data_mem_responder_if.slave bus
);

    localparam int               AW       = $clog2(DEPTH_WORDS);
    localparam bit               ZERO_LAT = (LATENCY == 0);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             we_reg;
    logic [31:0]      addr_reg;
    logic [31:0]      wdata_reg;
`ifdef BYTE_STROBE_EN
    logic [3:0]       be_reg;
`endif
    logic             rsp_valid_reg;
    logic             rsp_err_reg;

    logic             is_idle;
    logic             accept;
    logic             take;
    logic             exec;
    logic             x_we;
    logic [31:0]      x_addr;
    logic [31:0]      x_wdata;
    logic [3:0]       x_be;
    logic             x_err;
    logic             arr_we;
    logic             arr_rd;
    logic             arr_clr;
    logic [31:0]      arr_rdata;

    assign is_idle = (state_reg == ST_IDLE);
    assign accept  = is_idle && bus.REQ_VALID;
    assign take    = (state_reg == ST_RESP) && bus.RSP_READY;
    assign exec    = (accept && ZERO_LAT) ||
                     ((state_reg == ST_WAIT) && (cnt_reg == CNT_W'(1)));

    // With zero latency the access runs on the acceptance edge straight from the request.
    assign x_we    = is_idle ? bus.REQ_WE    : we_reg;
    assign x_addr  = is_idle ? bus.REQ_ADDR  : addr_reg;
    assign x_wdata = is_idle ? bus.REQ_WDATA : wdata_reg;
`ifdef BYTE_STROBE_EN
    assign x_be    = is_idle ? bus.REQ_BE    : be_reg;
`else
    assign x_be    = 4'hF;
`endif

    assign x_err   = (x_addr[1:0] != 2'b00) ||
                     ({2'b00, x_addr[31:2]} >= 32'(DEPTH_WORDS));

    assign arr_we  = exec && x_we && !x_err;
    assign arr_rd  = exec && !x_we && !x_err;
    assign arr_clr = (exec && (x_we || x_err)) || take;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
`ifdef BYTE_STROBE_EN
            be_reg        <= '0;
`endif
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        we_reg    <= bus.REQ_WE;
                        addr_reg  <= bus.REQ_ADDR;
                        wdata_reg <= bus.REQ_WDATA;
`ifdef BYTE_STROBE_EN
                        be_reg    <= bus.REQ_BE;
`endif
                        if (ZERO_LAT) begin
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= x_err;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= LAT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (exec) begin
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= x_err;
                    end
                end
                ST_RESP: begin
                    if (take) begin
                        state_reg     <= ST_IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (CLK),
        .rst_n (RESET_N),
        .we    (arr_we),
        .be    (x_be),
        .rd_en (arr_rd),
        .clr   (arr_clr),
        .addr  (x_addr[AW+1:2]),
        .wdata (x_wdata),
        .rdata (arr_rdata)
    );

    assign bus.REQ_READY = is_idle;
    assign bus.BUSY      = !is_idle;
    assign bus.RSP_VALID = rsp_valid_reg;
    assign bus.RSP_ERR   = rsp_err_reg;
    assign bus.RSP_RDATA = arr_rdata;

endmodule
